// File: rtl/fetch_request_unit.sv
// Multicycle fetch/execute/memory sequencer between the PC and the memory interface.
// It latches the fetched instruction, issues data accesses, pulses pcenable once per retire, and owns the sticky halt.
module fetch_request_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc_addr,
  output logic [31:0] imemaddr,
  output logic        imemREN,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        dren_req,
  input  logic        dwen_req,
  output logic        dmemREN,
  output logic        dmemWEN,
  input  logic        dhit,
  input  logic        halt_in,
  output logic        pcenable,
  output logic        halt
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] EXEC   = 2'd1;
  localparam logic [1:0] MEM    = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        mem_wr_q, mem_wr_d;
  logic        halt_q, halt_d;

  assign imemaddr = pc_addr;
  assign instr    = instr_q;
  assign halt     = halt_q;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    mem_wr_d    = mem_wr_q;
    halt_d      = halt_q;
    imemREN     = 1'b0;
    instr_valid = 1'b0;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    pcenable    = 1'b0;
    case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          instr_d = imemload;
          state_d = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        // Store wins when control raises both data requests.
        if (halt_in) begin
          halt_d  = 1'b1;
          state_d = HALTED;
        end else if (dwen_req) begin
          mem_wr_d = 1'b1;
          state_d  = MEM;
        end else if (dren_req) begin
          mem_wr_d = 1'b0;
          state_d  = MEM;
        end else begin
          pcenable = 1'b1;
          state_d  = FETCH;
        end
      end
      MEM: begin
        instr_valid = 1'b1;
        dmemWEN     = mem_wr_q;
        dmemREN     = !mem_wr_q;
        if (dhit) begin
          pcenable = 1'b1;
          state_d  = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= FETCH;
      instr_q  <= '0;
      mem_wr_q <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      mem_wr_q <= mem_wr_d;
      halt_q   <= halt_d;
    end
  end

endmodule

// File: tb/tb_fetch_request_unit.sv
// Directed bench for fetch_request_unit: reset, ALU retire, load/store waits, stray hits, reset mid-access, halt.
module tb_fetch_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] pc_addr;
  logic [31:0] imemaddr;
  logic        imemREN;
  logic        ihit;
  logic [31:0] imemload;
  logic [31:0] instr;
  logic        instr_valid;
  logic        dren_req;
  logic        dwen_req;
  logic        dmemREN;
  logic        dmemWEN;
  logic        dhit;
  logic        halt_in;
  logic        pcenable;
  logic        halt;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int p0;

  fetch_request_unit dut (
    .CLK(CLK), .nRST(nRST), .pc_addr(pc_addr), .imemaddr(imemaddr), .imemREN(imemREN),
    .ihit(ihit), .imemload(imemload), .instr(instr), .instr_valid(instr_valid),
    .dren_req(dren_req), .dwen_req(dwen_req), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dhit(dhit), .halt_in(halt_in), .pcenable(pcenable), .halt(halt)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (pcenable === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; pc_addr = 32'h0; ihit = 1'b1; imemload = 32'hDEADBEEF;
    dren_req = 1'b0; dwen_req = 1'b0; dhit = 1'b0; halt_in = 1'b0;
    repeat (2) tick();
    #2;
    check("rst_instr", instr, 32'h0);
    check("rst_imemREN", imemREN, 1);
    check("rst_pcenable", pcenable, 0);
    check("rst_halt", halt, 0);
    check("rst_ivalid", instr_valid, 0);
    check("rst_dreq", {dmemREN, dmemWEN}, 0);

    nRST = 1'b1;
    tick();
    ihit = 1'b0; #2;
    check("rel_instr", instr, 32'hDEADBEEF);
    check("rel_ivalid", instr_valid, 1);
    check("rel_imemREN", imemREN, 0);
    check("rel_pcen", pcenable, 1);
    tick(); #2;
    check("rel_fetch_ren", imemREN, 1);
    check("rel_fetch_pcen", pcenable, 0);

    // ALU run: one pcenable per two cycles
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      pc_addr = 32'h100 + 32'(4 * i); ihit = 1'b1; imemload = 32'h20000000 + 32'(i);
      #2;
      check("alu_iaddr", imemaddr, 32'h100 + 32'(4 * i));
      check("alu_fetch_ren", imemREN, 1);
      check("alu_fetch_pcen", pcenable, 0);
      tick();
      ihit = 1'b0; #2;
      check("alu_instr", instr, 32'h20000000 + 32'(i));
      check("alu_exec_pcen", pcenable, 1);
      tick();
    end
    check("alu_pulses", 32'(pulses - p0), 4);

    // Load with three wait states
    ihit = 1'b1; imemload = 32'h8C220004;
    tick();
    ihit = 1'b0; dren_req = 1'b1; #2;
    check("ld_exec_pcen", pcenable, 0);
    check("ld_exec_dren", dmemREN, 0);
    tick();
    dren_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("ld_wait_dren", dmemREN, 1);
      check("ld_wait_dwen", dmemWEN, 0);
      check("ld_wait_pcen", pcenable, 0);
      check("ld_wait_instr", instr, 32'h8C220004);
      tick();
    end
    dhit = 1'b1; #2;
    check("ld_hit_pcen", pcenable, 1);
    check("ld_hit_dren", dmemREN, 1);
    tick();
    dhit = 1'b0; #2;
    check("ld_after_dren", dmemREN, 0);
    check("ld_after_ren", imemREN, 1);

    // Store with simultaneous load request
    ihit = 1'b1; imemload = 32'hAC220008;
    tick();
    ihit = 1'b0; dwen_req = 1'b1; dren_req = 1'b1;
    tick();
    dwen_req = 1'b0; dren_req = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 2; i++) begin
      #2;
      check("st_wait_dwen", dmemWEN, 1);
      check("st_wait_dren", dmemREN, 0);
      tick();
    end
    dhit = 1'b1; #2;
    check("st_hit_pcen", pcenable, 1);
    tick();
    dhit = 1'b0; #2;
    check("st_pulses", 32'(pulses - p0), 1);
    check("st_after_dwen", dmemWEN, 0);

    // Stray dhit in FETCH leaves state alone
    dhit = 1'b1; ihit = 1'b0;
    tick(); #2;
    check("stray_f_ren", imemREN, 1);
    check("stray_f_instr", instr, 32'hAC220008);
    dhit = 1'b0; ihit = 1'b1; imemload = 32'h00000020;
    tick();
    // Stray dhit in EXEC does not complete the store it starts
    ihit = 1'b0; dhit = 1'b1; dwen_req = 1'b1; #2;
    check("stray_e_pcen", pcenable, 0);
    tick();
    dhit = 1'b0; dwen_req = 1'b0; #2;
    check("stray_m_dwen", dmemWEN, 1);
    check("stray_m_pcen", pcenable, 0);

    // Asynchronous reset mid-MEM
    p0 = pulses;
    nRST = 1'b0; #1;
    check("rstmem_dwen", dmemWEN, 0);
    check("rstmem_instr", instr, 32'h0);
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("rstmem_ren", imemREN, 1);
      check("rstmem_pcen", pcenable, 0);
      tick();
    end
    check("rstmem_pulses", 32'(pulses - p0), 0);

    // Halt is sticky
    ihit = 1'b1; imemload = 32'hFFFFFFFF;
    tick();
    ihit = 1'b0; halt_in = 1'b1; #2;
    check("hlt_exec_pcen", pcenable, 0);
    check("hlt_exec_halt", halt, 0);
    tick();
    halt_in = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 21; i++) begin
      ihit = i[0]; dhit = ~i[0]; #2;
      check("hlt_halt", halt, 1);
      check("hlt_reqs", {imemREN, dmemREN, dmemWEN, pcenable, instr_valid}, 0);
      tick();
    end
    check("hlt_pulses", 32'(pulses - p0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_request_unit.md
# fetch_request_unit

Multicycle sequencer between the program counter and the memory interface. It takes the current PC address, issues the instruction read, and latches the returned word as the current instruction. It issues any data read or write that instruction requires, then pulses `pcenable` so the PC advances. It also owns the sticky halt.

## Interface
- No parameters.
- CLK  in  1  system clock, all state updates on rising edge
- nRST  in  1  reset: asynchronous, active-low
- pc_addr  in  32  current PC value (PC register output)
- imemaddr  out  32  instruction address; combinational copy of pc_addr
- imemREN  out  1  instruction read request
- ihit  in  1  instruction read complete; imemload valid this cycle
- imemload  in  32  instruction word from memory
- instr  out  32  latched current instruction
- instr_valid  out  1  instr holds a fetched, not-yet-retired instruction
- dren_req  in  1  decoded from instr by control: instruction is a load
- dwen_req  in  1  decoded from instr by control: instruction is a store
- dmemREN  out  1  data read request
- dmemWEN  out  1  data write request
- dhit  in  1  data access complete
- halt_in  in  1  decoded from instr: instruction is HALT
- pcenable  out  1  one-cycle pulse; PC loads its next value on the following edge
- halt  out  1  sticky halted flag

## Operation
- FSM states: FETCH, EXEC, MEM, HALTED. Reset state is FETCH.
- Registered state: state, instr[31:0], mem_wr (1 = store pending), halt.
- **FETCH**
  - imemREN=1; instr_valid=0.
  - On ihit: instr <= imemload, go to EXEC.
  - Without ihit: stay in FETCH, request held.
- **EXEC**
  - imemREN=0; instr_valid=1.
  - Priority is halt_in > memory request > retire.
  - If halt_in: halt <= 1, go to HALTED, pcenable=0.
  - Else if dwen_req: mem_wr <= 1, go to MEM.
  - Else if dren_req: mem_wr <= 0, go to MEM.
  - Else: pcenable=1 this cycle, go to FETCH.
- **MEM**
  - instr_valid=1; dmemWEN=mem_wr; dmemREN=!mem_wr. Never both high.
  - On dhit: pcenable=1 this cycle, go to FETCH; both requests drop the next cycle.
  - dren_req, dwen_req and halt_in are ignored in MEM.
- **HALTED**
  - Terminal until nRST.
  - All requests 0; pcenable=0; instr_valid=0; halt=1.
- dren_req and dwen_req both high in EXEC: treated as a store.
- imemaddr = pc_addr in every state; only imemREN qualifies it.
- ihit outside FETCH and dhit outside MEM are ignored and change no state.
- pcenable is combinational from state and inputs. It is high in exactly one cycle per retired instruction and never in FETCH or HALTED.

## Timing
- Reset values, held while nRST=0:
  - state=FETCH, instr=0, mem_wr=0, halt=0.
  - Outputs: imemREN=1, instr_valid=0, dmemREN=0, dmemWEN=0, pcenable=0.
- Reset asserted mid-MEM or mid-FETCH drops dmemREN/dmemWEN immediately (asynchronous) and discards the instruction. The PC is not advanced.
- Minimum latency with ihit in the first FETCH cycle:
  - Non-memory instruction: 2 cycles (FETCH, EXEC with pcenable).
  - Load/store with dhit in the first MEM cycle: 3 cycles.
- The PC updates on the edge ending the pcenable cycle. The next FETCH cycle therefore presents the new pc_addr.
- instr changes only on the FETCH→EXEC edge and is stable through EXEC and MEM.
- Data requests are held level until dhit. Wait states are unbounded.

## Test plan
- **Reset:** nRST=0 with ihit=1 and imemload=0xDEADBEEF → instr=0, imemREN=1, pcenable=0, halt=0. Release and hold ihit=1 → instr=0xDEADBEEF after one edge.
- **ALU instruction:** ihit on cycle 1, no requests → cycle 2 has instr_valid=1 and pcenable=1. Cycle 3 is FETCH with imemREN=1. Repeated, this gives exactly one pcenable pulse per 2 cycles.
- **Load with waits:**
  - Fetch 0x8C220004, then dren_req=1 in EXEC → dmemREN=1 for 3 cycles while dhit=0, with pcenable=0 throughout.
  - dhit=1 on the 4th cycle → pcenable=1 that cycle; dmemREN=0 next cycle.
- **Store with a simultaneous load request:** dwen_req=1 and dren_req=1 in EXEC → dmemWEN=1, dmemREN=0 until dhit. Exactly one pcenable pulse.
- **Halt:** fetch 0xFFFFFFFF with halt_in=1 → halt=1 next cycle and stays 1 for 20 further cycles with ihit and dhit toggling. pcenable, imemREN, dmemREN and dmemWEN all stay 0.
- **Stray hits and reset mid-access:**
  - dhit pulsed in FETCH and EXEC → no state change.
  - nRST=0 mid-MEM → dmemWEN drops in the same cycle. After release the unit fetches with pcenable never asserted.
